// File: rtl/cuckoo_pkg.sv
// Shared defaults, FSM state type and a saturating counter helper for the cuckoo insert controller.
package cuckoo_pkg;

    localparam int KEY_W_DEF     = 32;
    localparam int IDX_W_DEF     = 4;
    localparam int MAX_KICKS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cuckoo_insert_ctrl_if.sv
// Request/table/completion bundle between the insert controller (master) and its environment (slave).
interface cuckoo_insert_ctrl_if #(
    parameter int KEY_W = 32,
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [KEY_W-1:0] in_key;
    logic             tbl_req;
    logic             tbl_sel;
    logic [IDX_W-1:0] tbl_idx;
    logic [KEY_W-1:0] tbl_key;
    logic             tbl_ack;
    logic             tbl_evict;
    logic [KEY_W-1:0] tbl_evict_key;
    logic             done;
    logic             done_ok;
    logic [KEY_W-1:0] fail_key;

    modport master (
        input  in_valid, in_key, tbl_ack, tbl_evict, tbl_evict_key,
        output in_ready, tbl_req, tbl_sel, tbl_idx, tbl_key, done, done_ok, fail_key
    );

    modport slave (
        output in_valid, in_key, tbl_ack, tbl_evict, tbl_evict_key,
        input  in_ready, tbl_req, tbl_sel, tbl_idx, tbl_key, done, done_ok, fail_key
    );
endinterface

// File: rtl/cuckoo_hash.sv
// Bucket index hash: table 0 takes the low key slice, table 1 folds all slices together with XOR.
module cuckoo_hash
    import cuckoo_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             sel,
    input  logic [KEY_W-1:0] key,
    output logic [IDX_W-1:0] idx
);
    localparam int SLICES = KEY_W / IDX_W;

    logic [IDX_W-1:0] folded;

    always_comb begin
        folded = '0;
        for (int i = 0; i < SLICES; i++) begin
            folded = folded ^ key[i*IDX_W +: IDX_W];
        end
        idx = sel ? folded : key[IDX_W-1:0];
    end

endmodule

// File: rtl/cuckoo_insert_ctrl.sv
// Cuckoo hash insert sequencer: places a key, chasing evicted keys between two tables up to MAX_KICKS.
// Optional saturating statistics counters are enabled with CUCKOO_STATS_EN.
//
// state | meaning
// IDLE  | ready for a new key
// ISSUE | tbl_req pulse for cur_key into tbl_sel/tbl_idx
// WAIT  | holding command until tbl_ack
// DONE  | done pulse, result on done_ok / fail_key
module cuckoo_insert_ctrl
    import cuckoo_pkg::*;
#(
    parameter int KEY_W     = KEY_W_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int MAX_KICKS = MAX_KICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    cuckoo_insert_ctrl_if.master bus
`ifdef CUCKOO_STATS_EN
    ,
    output logic [15:0] stat_inserts,
    output logic [15:0] stat_kicks,
    output logic [15:0] stat_fails
`endif
);
    localparam logic [7:0] MAX_K = 8'(MAX_KICKS);

    state_t           state;
    logic [KEY_W-1:0] cur_key;
    logic [7:0]       kicks;
    logic [7:0]       kicks_nxt;
    logic             hash_sel;
    logic [KEY_W-1:0] hash_key;
    logic [IDX_W-1:0] hash_idx;
    logic             accept;
    logic             evict_ack;
    logic             give_up;

    // One hash serves both entry points: a fresh key from IDLE, or the displaced key from WAIT.
    assign hash_sel  = (state == WAIT) ? ~bus.tbl_sel : 1'b0;
    assign hash_key  = (state == WAIT) ? bus.tbl_evict_key : bus.in_key;
    assign kicks_nxt = kicks + 8'd1;
    assign accept    = (state == IDLE) && bus.in_valid;
    assign evict_ack = (state == WAIT) && bus.tbl_ack && bus.tbl_evict;
    assign give_up   = evict_ack && (kicks_nxt == MAX_K);
    assign bus.tbl_key = cur_key;

    cuckoo_hash #(.KEY_W(KEY_W), .IDX_W(IDX_W)) u_hash (
        .sel (hash_sel),
        .key (hash_key),
        .idx (hash_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_key      <= '0;
            kicks        <= '0;
            bus.in_ready <= 1'b1;
            bus.tbl_req  <= 1'b0;
            bus.tbl_sel  <= 1'b0;
            bus.tbl_idx  <= '0;
            bus.done     <= 1'b0;
            bus.done_ok  <= 1'b0;
            bus.fail_key <= '0;
        end else begin
            bus.tbl_req <= 1'b0;
            bus.done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_key      <= bus.in_key;
                        kicks        <= '0;
                        bus.tbl_sel  <= 1'b0;
                        bus.tbl_idx  <= hash_idx;
                        bus.tbl_req  <= 1'b1;
                        bus.in_ready <= 1'b0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (bus.tbl_ack) begin
                        if (!bus.tbl_evict) begin
                            bus.done    <= 1'b1;
                            bus.done_ok <= 1'b1;
                            state       <= DONE;
                        end else begin
                            kicks <= kicks_nxt;
                            if (give_up) begin
                                bus.done     <= 1'b1;
                                bus.done_ok  <= 1'b0;
                                bus.fail_key <= bus.tbl_evict_key;
                                state        <= DONE;
                            end else begin
                                cur_key     <= bus.tbl_evict_key;
                                bus.tbl_sel <= ~bus.tbl_sel;
                                bus.tbl_idx <= hash_idx;
                                bus.tbl_req <= 1'b1;
                                state       <= ISSUE;
                            end
                        end
                    end
                end
                DONE: begin
                    bus.in_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    bus.in_ready <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef CUCKOO_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_inserts <= '0;
            stat_kicks   <= '0;
            stat_fails   <= '0;
        end else begin
            if (accept)    stat_inserts <= sat_inc16(stat_inserts);
            if (evict_ack) stat_kicks   <= sat_inc16(stat_kicks);
            if (give_up)   stat_fails   <= sat_inc16(stat_fails);
        end
    end
`endif

endmodule

// File: tb/tb_cuckoo_insert_ctrl.sv
// Directed bench for cuckoo_insert_ctrl: default-parameter instance plus a MAX_KICKS=2 instance.
module tb_cuckoo_insert_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int done_cnt_a = 0;
    int req_cnt_b = 0;

    always #5 clk = ~clk;

    cuckoo_insert_ctrl_if #(.KEY_W(32), .IDX_W(4)) ia ();
    cuckoo_insert_ctrl_if #(.KEY_W(32), .IDX_W(4)) ib ();

`ifdef CUCKOO_STATS_EN
    logic [15:0] sa_ins, sa_kick, sa_fail, sb_ins, sb_kick, sb_fail;
`endif

    cuckoo_insert_ctrl #(.KEY_W(32), .IDX_W(4), .MAX_KICKS(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia)
`ifdef CUCKOO_STATS_EN
        , .stat_inserts(sa_ins), .stat_kicks(sa_kick), .stat_fails(sa_fail)
`endif
    );

    cuckoo_insert_ctrl #(.KEY_W(32), .IDX_W(4), .MAX_KICKS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib)
`ifdef CUCKOO_STATS_EN
        , .stat_inserts(sb_ins), .stat_kicks(sb_kick), .stat_fails(sb_fail)
`endif
    );

    always @(negedge clk) begin
        if (ia.done === 1'b1) done_cnt_a++;
        if (ib.tbl_req === 1'b1) req_cnt_b++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ia.in_valid = 0; ia.in_key = '0; ia.tbl_ack = 0; ia.tbl_evict = 0; ia.tbl_evict_key = '0;
        ib.in_valid = 0; ib.in_key = '0; ib.tbl_ack = 0; ib.tbl_evict = 0; ib.tbl_evict_key = '0;
        rst_n = 0;
        step(); step();
        rst_n = 1;
        step();
        checks++; if (ia.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", ia.in_ready); end
        checks++; if (ia.tbl_req !== 1'b0) begin failures++; $display("FAIL reset_tbl_req got=%0h exp=0", ia.tbl_req); end
        checks++; if (ia.done !== 1'b0 || ia.done_ok !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h/%0h exp=0/0", ia.done, ia.done_ok); end
        checks++; if (ia.tbl_sel !== 1'b0 || ia.tbl_idx !== 4'h0) begin failures++; $display("FAIL reset_sel_idx got=%0h/%0h exp=0/0", ia.tbl_sel, ia.tbl_idx); end
        checks++; if (ia.tbl_key !== 32'h0 || ia.fail_key !== 32'h0) begin failures++; $display("FAIL reset_keys got=%0h/%0h exp=0/0", ia.tbl_key, ia.fail_key); end
`ifdef CUCKOO_STATS_EN
        checks++; if (sa_ins !== 16'd0 || sa_kick !== 16'd0 || sa_fail !== 16'd0) begin failures++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", sa_ins, sa_kick, sa_fail); end
`endif
    endtask

    task automatic test_insert_ok();
        int d0;
        d0 = done_cnt_a;
        ia.in_valid = 1; ia.in_key = 32'h12;
        step();
        ia.in_valid = 0;
        checks++; if (ia.tbl_req !== 1'b1 || ia.tbl_sel !== 1'b0 || ia.tbl_idx !== 4'h2 || ia.tbl_key !== 32'h12) begin
            failures++; $display("FAIL ok_issue got req=%0h sel=%0h idx=%0h key=%0h exp 1/0/2/12", ia.tbl_req, ia.tbl_sel, ia.tbl_idx, ia.tbl_key); end
        checks++; if (ia.in_ready !== 1'b0) begin failures++; $display("FAIL ok_in_ready_busy got=%0h exp=0", ia.in_ready); end
        step();
        checks++; if (ia.tbl_req !== 1'b0 || ia.tbl_idx !== 4'h2 || ia.tbl_key !== 32'h12 || ia.done !== 1'b0) begin
            failures++; $display("FAIL ok_wait got req=%0h idx=%0h key=%0h done=%0h exp 0/2/12/0", ia.tbl_req, ia.tbl_idx, ia.tbl_key, ia.done); end
        ia.tbl_ack = 1; ia.tbl_evict = 0;
        step();
        ia.tbl_ack = 0;
        checks++; if (ia.done !== 1'b1 || ia.done_ok !== 1'b1) begin failures++; $display("FAIL ok_done got=%0h/%0h exp=1/1", ia.done, ia.done_ok); end
        step();
        checks++; if (ia.done !== 1'b0 || ia.in_ready !== 1'b1) begin failures++; $display("FAIL ok_back_idle got done=%0h rdy=%0h exp 0/1", ia.done, ia.in_ready); end
        checks++; if (done_cnt_a - d0 !== 1) begin failures++; $display("FAIL ok_done_pulses got=%0d exp=1", done_cnt_a - d0); end
    endtask

    task automatic test_evict();
        ia.in_valid = 1; ia.in_key = 32'h12;
        step();
        ia.in_valid = 0;
        step();
        ia.tbl_ack = 1; ia.tbl_evict = 1; ia.tbl_evict_key = 32'h34;
        step();
        ia.tbl_ack = 0; ia.tbl_evict = 0;
        checks++; if (ia.tbl_req !== 1'b1 || ia.tbl_sel !== 1'b1 || ia.tbl_idx !== 4'h7 || ia.tbl_key !== 32'h34) begin
            failures++; $display("FAIL evict_reissue got req=%0h sel=%0h idx=%0h key=%0h exp 1/1/7/34", ia.tbl_req, ia.tbl_sel, ia.tbl_idx, ia.tbl_key); end
        checks++; if (ia.done !== 1'b0) begin failures++; $display("FAIL evict_no_done got=%0h exp=0", ia.done); end
        step();
        ia.tbl_ack = 1;
        step();
        ia.tbl_ack = 0;
        checks++; if (ia.done !== 1'b1 || ia.done_ok !== 1'b1) begin failures++; $display("FAIL evict_done got=%0h/%0h exp=1/1", ia.done, ia.done_ok); end
        step();
    endtask

    task automatic test_ignore_valid();
        ia.in_valid = 1; ia.in_key = 32'h12;
        step();
        ia.in_key = 32'h55;
        step();
        step();
        checks++; if (ia.in_ready !== 1'b0 || ia.tbl_key !== 32'h12 || ia.tbl_req !== 1'b0) begin
            failures++; $display("FAIL ignore_wait got rdy=%0h key=%0h req=%0h exp 0/12/0", ia.in_ready, ia.tbl_key, ia.tbl_req); end
        ia.tbl_ack = 1; ia.tbl_evict = 0;
        step();
        ia.tbl_ack = 0;
        checks++; if (ia.in_ready !== 1'b0 || ia.done !== 1'b1) begin failures++; $display("FAIL ignore_done got rdy=%0h done=%0h exp 0/1", ia.in_ready, ia.done); end
        step();
        checks++; if (ia.in_ready !== 1'b1) begin failures++; $display("FAIL ignore_idle_ready got=%0h exp=1", ia.in_ready); end
        step();
        ia.in_valid = 0;
        checks++; if (ia.tbl_req !== 1'b1 || ia.tbl_key !== 32'h55 || ia.tbl_idx !== 4'h5 || ia.tbl_sel !== 1'b0) begin
            failures++; $display("FAIL ignore_accept55 got req=%0h key=%0h idx=%0h sel=%0h exp 1/55/5/0", ia.tbl_req, ia.tbl_key, ia.tbl_idx, ia.tbl_sel); end
        step();
        ia.tbl_ack = 1;
        step();
        ia.tbl_ack = 0;
        step();
    endtask

    task automatic test_reset_wait();
        int d0;
        d0 = done_cnt_a;
        ia.in_valid = 1; ia.in_key = 32'h12;
        step();
        ia.in_valid = 0;
        step();
        rst_n = 0;
        #1;
        checks++; if (ia.tbl_req !== 1'b0 || ia.in_ready !== 1'b1 || ia.tbl_key !== 32'h0) begin
            failures++; $display("FAIL rstwait_async got req=%0h rdy=%0h key=%0h exp 0/1/0", ia.tbl_req, ia.in_ready, ia.tbl_key); end
        step();
        rst_n = 1;
        ia.tbl_ack = 1; ia.tbl_evict = 1; ia.tbl_evict_key = 32'hDEAD;
        step(); step(); step();
        ia.tbl_ack = 0; ia.tbl_evict = 0;
        checks++; if (ia.tbl_req !== 1'b0 || ia.in_ready !== 1'b1 || ia.done !== 1'b0) begin
            failures++; $display("FAIL rstwait_stray_ack got req=%0h rdy=%0h done=%0h exp 0/1/0", ia.tbl_req, ia.in_ready, ia.done); end
        checks++; if (done_cnt_a - d0 !== 0) begin failures++; $display("FAIL rstwait_no_done got=%0d exp=0", done_cnt_a - d0); end
    endtask

    task automatic test_max_kicks();
        int r0;
        ib.in_valid = 1; ib.in_key = 32'h12;
        step();
        ib.in_valid = 0;
        step();
        ib.tbl_ack = 1; ib.tbl_evict = 0;
        step();
        ib.tbl_ack = 0;
        step();
        r0 = req_cnt_b;
        ib.in_valid = 1; ib.in_key = 32'h12;
        step();
        ib.in_valid = 0;
        step();
        ib.tbl_ack = 1; ib.tbl_evict = 1; ib.tbl_evict_key = 32'hA1;
        step();
        ib.tbl_ack = 0;
        checks++; if (ib.tbl_req !== 1'b1 || ib.tbl_sel !== 1'b1 || ib.tbl_idx !== 4'hB || ib.tbl_key !== 32'hA1) begin
            failures++; $display("FAIL kick_req2 got req=%0h sel=%0h idx=%0h key=%0h exp 1/1/b/a1", ib.tbl_req, ib.tbl_sel, ib.tbl_idx, ib.tbl_key); end
        step();
        ib.tbl_ack = 1; ib.tbl_evict = 1; ib.tbl_evict_key = 32'hB2;
        step();
        ib.tbl_ack = 0; ib.tbl_evict = 0;
        checks++; if (ib.done !== 1'b1 || ib.done_ok !== 1'b0 || ib.fail_key !== 32'hB2) begin
            failures++; $display("FAIL kick_fail got done=%0h ok=%0h key=%0h exp 1/0/b2", ib.done, ib.done_ok, ib.fail_key); end
        step(); step(); step();
        checks++; if (req_cnt_b - r0 !== 2) begin failures++; $display("FAIL kick_req_count got=%0d exp=2", req_cnt_b - r0); end
        checks++; if (ib.in_ready !== 1'b1) begin failures++; $display("FAIL kick_idle got=%0h exp=1", ib.in_ready); end
`ifdef CUCKOO_STATS_EN
        checks++; if (sb_ins !== 16'd2 || sb_kick !== 16'd2 || sb_fail !== 16'd1) begin
            failures++; $display("FAIL stats got=%0d/%0d/%0d exp=2/2/1", sb_ins, sb_kick, sb_fail); end
`endif
    endtask

    initial begin
        test_reset();
        test_insert_ok();
        test_evict();
        test_ignore_valid();
        test_reset_wait();
        test_max_kicks();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
